// File: rtl/img_loader_pkg.sv
// Shared constants and state encoding for the image input stage and the
// multiply-accumulate array that consumes its frames.
package img_loader_pkg;

  localparam int IMG_SIDE = 28;
  localparam int PIX_NUM  = IMG_SIDE * IMG_SIDE;
  localparam int PIX_W    = 8;
  localparam int IMG_BITS = PIX_NUM * PIX_W;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } ld_state_e;

endpackage

// File: rtl/img_loader.sv
// Byte-serial pixel stream to flat image bus, double-buffered: one frame
// assembles in the fill buffer while the previous one is held on IMG.
module img_loader
  #(parameter int PIX_NUM = img_loader_pkg::PIX_NUM,
    parameter int PIX_W   = img_loader_pkg::PIX_W)
  (input  logic                     CLK,
   input  logic                     RESET_X,
   input  logic [PIX_W-1:0]         PIX_DATA,
   input  logic                     PIX_VALID,
   input  logic                     PIX_LAST,
   output logic                     PIX_READY,
   output logic [PIX_NUM*PIX_W-1:0] IMG,
   output logic                     IMG_VALID,
   input  logic                     IMG_ACK,
   output logic                     FRAME_ERR,
   output logic [15:0]              FRAME_CNT);

  import img_loader_pkg::*;

  localparam int               IDX_W    = $clog2(PIX_NUM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_NUM - 1);

  ld_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [PIX_NUM-1:0][PIX_W-1:0]   fill_q, fill_d;
  logic [PIX_NUM-1:0][PIX_W-1:0]   hold_q, hold_d;
  logic                            img_valid_q, img_valid_d;
  logic                            frame_err_q, frame_err_d;
  logic [15:0]                     frame_cnt_q, frame_cnt_d;
  logic                            accept_s;
  logic                            hold_free_s;

  // Ready is the only combinational output; it must drop during reset.
  assign PIX_READY   = (state_q == ST_FILL) && !RESET_X;
  assign accept_s    = PIX_VALID && PIX_READY;
  assign hold_free_s = !img_valid_q || IMG_ACK;

  assign IMG       = hold_q;
  assign IMG_VALID = img_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign FRAME_CNT = frame_cnt_q;

  // Next-state, buffer write and framing check.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_d      = fill_q;
    hold_d      = hold_q;
    img_valid_d = img_valid_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      ST_FILL: begin
        // A plain ack frees the hold; a completing beat below may refill it.
        if (IMG_ACK && img_valid_q) begin
          img_valid_d = 1'b0;
        end else begin
          img_valid_d = img_valid_q;
        end

        if (accept_s) begin
          fill_d[idx_q] = PIX_DATA;
          if (idx_q == LAST_IDX) begin
            idx_d = {IDX_W{1'b0}};
            if (!PIX_LAST) begin
              frame_err_d = 1'b1;
            end else if (hold_free_s) begin
              hold_d      = fill_d;
              img_valid_d = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
              state_d = ST_FULL;
            end
          end else if (PIX_LAST) begin
            frame_err_d = 1'b1;
            idx_d       = {IDX_W{1'b0}};
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end

      ST_FULL: begin
        // IMG_VALID is always set here, so the ack is never ignored.
        if (IMG_ACK) begin
          hold_d      = fill_q;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_FILL;
        end else begin
          state_d = ST_FULL;
        end
      end

      default: begin
        state_d = ST_FILL;
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Control and hold registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET_X) begin
      state_q     <= ST_FILL;
      idx_q       <= {IDX_W{1'b0}};
      hold_q      <= '0;
      img_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hold_q      <= hold_d;
      img_valid_q <= img_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Fill buffer keeps its contents across reset; every slot is rewritten
  // before it can reach IMG.
  always_ff @(posedge CLK) begin
    fill_q <= fill_d;
  end

endmodule

// File: tb/tb_img_loader.sv
// Directed self-checking bench for img_loader.
module tb_img_loader;

  localparam int NPIX = img_loader_pkg::PIX_NUM;

  logic                                CLK;
  logic                                RESET_X;
  logic [7:0]                          PIX_DATA;
  logic                                PIX_VALID;
  logic                                PIX_LAST;
  logic                                PIX_READY;
  logic [img_loader_pkg::IMG_BITS-1:0] IMG;
  logic                                IMG_VALID;
  logic                                IMG_ACK;
  logic                                FRAME_ERR;
  logic [15:0]                         FRAME_CNT;

  int n_checks = 0;
  int n_fail   = 0;
  int stall_cnt = 0;
  int valid_drops = 0;
  int ready_drops = 0;
  logic mon_en = 1'b0;

  img_loader dut (
    .CLK      (CLK),
    .RESET_X  (RESET_X),
    .PIX_DATA (PIX_DATA),
    .PIX_VALID(PIX_VALID),
    .PIX_LAST (PIX_LAST),
    .PIX_READY(PIX_READY),
    .IMG      (IMG),
    .IMG_VALID(IMG_VALID),
    .IMG_ACK  (IMG_ACK),
    .FRAME_ERR(FRAME_ERR),
    .FRAME_CNT(FRAME_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (IMG_VALID !== 1'b1) valid_drops++;
      if (PIX_READY !== 1'b1) ready_drops++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mul, input int add, input int k);
    return 8'((k * mul + add) & 255);
  endfunction

  task automatic check_img(input string tag, input int mul, input int add);
    int bad = 0;
    for (int k = 0; k < NPIX; k++) begin
      if (IMG[k*8 +: 8] !== pat(mul, add, k)) bad++;
    end
    check_eq(tag, bad, 0);
  endtask

  task automatic drive_beat(input logic [7:0] d, input logic l, input logic ack);
    int waited = 0;
    @(negedge CLK);
    PIX_VALID = 1'b1;
    PIX_DATA  = d;
    PIX_LAST  = l;
    IMG_ACK   = ack;
    #1;
    while (!PIX_READY && waited < 2000) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    if (waited >= 2000) check_eq("beat_timeout", 32'd0, 32'd1);
    stall_cnt += waited;
  endtask

  task automatic idle();
    @(negedge CLK);
    PIX_VALID = 1'b0;
    PIX_LAST  = 1'b0;
    IMG_ACK   = 1'b0;
    #1;
  endtask

  task automatic send_frame(input int mul, input int add, input logic ack_last, input int exp_cnt);
    for (int k = 0; k < NPIX; k++) begin
      drive_beat(pat(mul, add, k), (k == NPIX - 1), ack_last && (k == NPIX - 1));
      if (k == 0 && exp_cnt >= 0) check_eq("b2b_cnt_step", FRAME_CNT, exp_cnt);
    end
  endtask

  initial begin
    RESET_X = 1'b1; PIX_VALID = 1'b0; PIX_LAST = 1'b0; PIX_DATA = 8'd0; IMG_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    check_eq("rst_ready", PIX_READY, 1'b0);
    check_eq("rst_valid", IMG_VALID, 1'b0);
    check_eq("rst_cnt", FRAME_CNT, 16'd0);
    check_eq("rst_err", FRAME_ERR, 1'b0);
    check_img("rst_img", 0, 0);
    RESET_X = 1'b0;
    #1;
    check_eq("ready_after_rst", PIX_READY, 1'b1);

    // First frame: ramp
    send_frame(1, 0, 1'b0, -1);
    idle();
    check_eq("f1_byte0", IMG[7:0], 8'h00);
    check_eq("f1_byte783", IMG[6271:6264], 8'h0F);
    check_img("f1_img", 1, 0);
    check_eq("f1_valid", IMG_VALID, 1'b1);
    check_eq("f1_cnt", FRAME_CNT, 16'd1);
    check_eq("f1_err", FRAME_ERR, 1'b0);

    // Second frame parks in FULL until acked
    send_frame(0, 170, 1'b0, -1);
    idle();
    check_eq("full_ready", PIX_READY, 1'b0);
    check_img("full_img_held", 1, 0);
    check_eq("full_cnt", FRAME_CNT, 16'd1);
    check_eq("full_valid", IMG_VALID, 1'b1);
    IMG_ACK = 1'b1;
    idle();
    check_eq("ack_ready", PIX_READY, 1'b1);
    check_img("ack_img_aa", 0, 170);
    check_eq("ack_cnt", FRAME_CNT, 16'd2);
    check_eq("ack_valid", IMG_VALID, 1'b1);

    // Back-to-back with ack on each completing beat
    stall_cnt = 0;
    mon_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      send_frame(3, 11 * f + 5, 1'b1, 2 + f);
    end
    idle();
    mon_en = 1'b0;
    check_eq("b2b_cnt", FRAME_CNT, 16'd5);
    check_img("b2b_img", 3, 27);
    check_eq("b2b_valid_drops", valid_drops, 0);
    check_eq("b2b_ready_drops", ready_drops, 0);
    check_eq("b2b_stalls", stall_cnt, 0);

    // Early PIX_LAST at beat 100
    for (int k = 0; k <= 100; k++) drive_beat(pat(1, 50, k), (k == 100), 1'b0);
    idle();
    check_eq("early_err", FRAME_ERR, 1'b1);
    check_eq("early_valid", IMG_VALID, 1'b1);
    check_eq("early_cnt", FRAME_CNT, 16'd5);
    check_img("early_img", 3, 27);
    idle();
    check_eq("early_err_pulse", FRAME_ERR, 1'b0);
    IMG_ACK = 1'b1;
    idle();
    check_eq("plain_ack_valid", IMG_VALID, 1'b0);
    send_frame(5, 1, 1'b0, -1);
    idle();
    check_img("after_early_img", 5, 1);
    check_eq("after_early_cnt", FRAME_CNT, 16'd6);
    check_eq("after_early_valid", IMG_VALID, 1'b1);

    // Missing PIX_LAST on beat 783
    for (int k = 0; k < NPIX; k++) drive_beat(pat(2, 9, k), 1'b0, 1'b0);
    idle();
    check_eq("miss_err", FRAME_ERR, 1'b1);
    check_eq("miss_cnt", FRAME_CNT, 16'd6);
    check_eq("miss_valid", IMG_VALID, 1'b1);
    check_eq("miss_ready", PIX_READY, 1'b1);
    check_img("miss_img", 5, 1);
    send_frame(7, 3, 1'b1, -1);
    idle();
    check_img("after_miss_img", 7, 3);
    check_eq("after_miss_cnt", FRAME_CNT, 16'd7);
    check_eq("after_miss_err", FRAME_ERR, 1'b0);

    // Reset in the middle of a frame while a frame is held
    for (int k = 0; k < 400; k++) drive_beat(pat(1, 100, k), 1'b0, 1'b0);
    @(negedge CLK);
    RESET_X = 1'b1;
    #1;
    check_eq("midrst_ready", PIX_READY, 1'b0);
    @(negedge CLK);
    #1;
    check_img("midrst_img", 0, 0);
    check_eq("midrst_valid", IMG_VALID, 1'b0);
    check_eq("midrst_cnt", FRAME_CNT, 16'd0);
    check_eq("midrst_err", FRAME_ERR, 1'b0);
    RESET_X   = 1'b0;
    PIX_VALID = 1'b0;
    send_frame(13, 200, 1'b0, -1);
    idle();
    check_img("post_rst_img", 13, 200);
    check_eq("post_rst_cnt", FRAME_CNT, 16'd1);
    check_eq("post_rst_valid", IMG_VALID, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/img_loader.md
# img_loader

Image input stage for the digit-classifier datapath. Accepts a byte-serial pixel stream with a valid/ready handshake and assembles it into the flat 28×28×8-bit image bus consumed by the multiply-accumulate array. It double-buffers: one frame assembles while the previous frame is held stable on `IMG` until the array acknowledges it. It also checks frame framing and flags errors.

## Interface
Parameters:
- `PIX_NUM`, 784: pixels per frame (28×28).
- `PIX_W`, 8: bits per pixel.

Ports:
- `CLK`  in  1  single clock; all logic is rising-edge.
- `RESET_X`  in  1  reset; synchronous, active-high.
- `PIX_DATA`  in  `PIX_W`  pixel byte, raster order, pixel 0 first.
- `PIX_VALID`  in  1  `PIX_DATA`/`PIX_LAST` are valid.
- `PIX_LAST`  in  1  marks the final pixel of a frame.
- `PIX_READY`  out  1  loader accepts a beat this cycle.
- `IMG`  out  `PIX_NUM*PIX_W`  held frame; pixel k at `[k*8+7:k*8]`.
- `IMG_VALID`  out  1  `IMG` holds an unconsumed frame.
- `IMG_ACK`  in  1  consumer takes `IMG` this cycle; ignored when `IMG_VALID`=0.
- `FRAME_ERR`  out  1  one-cycle pulse: framing error, frame discarded.
- `FRAME_CNT`  out  16  count of frames delivered to `IMG`; wraps at 65535→0.

## Operation
- Beat accepted iff `PIX_VALID && PIX_READY`. The pixel is written into fill-buffer slot `idx` (10-bit counter, 0..783).
- States:
  - FILL: `PIX_READY`=1.
  - FULL: complete frame waiting in the fill buffer; `PIX_READY`=0.
- Frame-completing beat (`idx`=783 and `PIX_LAST`=1):
  - If hold is free (`IMG_VALID`=0, or `IMG_ACK`=1 this cycle): `IMG` ← full frame, including this beat's byte. `IMG_VALID`=1. `FRAME_CNT`+1. `idx`←0. Stay in FILL.
  - Otherwise: latch the byte into the fill buffer, `idx`←0, go to FULL.
- FULL with `IMG_ACK`=1: `IMG` ← fill buffer, `IMG_VALID` stays 1, `FRAME_CNT`+1, go to FILL.
- `IMG_ACK` in FILL with no completing beat: `IMG_VALID`←0. `IMG` keeps its old value (don't-care).
- Framing errors. Either of the following pulses `FRAME_ERR` for one cycle, discards the partial frame, and sets `idx`←0. `IMG`/`IMG_VALID` are unaffected.
  - Early `PIX_LAST` (accepted beat with `PIX_LAST`=1 and `idx`<783).
  - Missing `PIX_LAST` (accepted beat at `idx`=783 with `PIX_LAST`=0).
- `PIX_DATA`/`PIX_LAST` are ignored when the beat is not accepted.
- Reset, including mid-frame: state FILL, `idx`=0, `IMG`=0, `IMG_VALID`=0, `FRAME_ERR`=0, `FRAME_CNT`=0. The fill buffer is not cleared. `PIX_READY`=0 in any cycle where `RESET_X`=1.

## Timing
- All outputs are registered except `PIX_READY`, which is decoded from state and gated by `RESET_X`.
- Latency: completing beat accepted at edge N → `IMG`/`IMG_VALID`/`FRAME_CNT` updated at edge N. Visible in cycle N+1.
- Throughput: 1 pixel/cycle, no bubble between frames while the consumer acks within 784 cycles.
- Simultaneous `IMG_ACK` and completing beat: the new frame replaces the old with no gap in `IMG_VALID`.
- From FULL, `IMG_ACK` at edge M → `PIX_READY`=1 in cycle M+1.
- `FRAME_ERR` asserts in the cycle after the offending beat, for exactly one cycle.

## Structure
- Shared package: `IMG_SIDE`=28, `PIX_NUM`, `PIX_W`, `IMG_BITS`=`PIX_NUM*PIX_W`, and the state encoding (FILL=0, FULL=1). The multiply-accumulate side uses the same package.
- Single module, no sub-module. Fill buffer and hold register are plain flop arrays with indexed byte write.

## Test plan
- Reset, then stream 784 beats with pixel k = k mod 256 and `PIX_LAST` on beat 783. Expect `IMG[7:0]`=0x00, `IMG[6271:6264]`=0x0F, `IMG_VALID`=1 and `FRAME_CNT`=1 the cycle after beat 783.
- Hold `IMG_ACK`=0 and send a second full frame (all 0xAA). Expect `PIX_READY`=0 after its last beat while `IMG` is unchanged. On ack: `IMG` all 0xAA, `FRAME_CNT`=2, `PIX_READY`=1 the next cycle.
- Back-to-back frames with `IMG_ACK` pulsed on each completing beat. Expect `IMG_VALID` to stay continuously 1, `PIX_READY` never to drop, and `FRAME_CNT` +1 per frame.
- `PIX_LAST` at beat 100. Expect a one-cycle `FRAME_ERR`, `IMG_VALID` unchanged, and the next 784-beat frame delivered correctly.
- Beat 783 sent without `PIX_LAST`. Expect `FRAME_ERR`, no delivery, `FRAME_CNT` unchanged.
- Assert `RESET_X` at beat 400 while `IMG_VALID`=1. Expect `IMG`=0, `IMG_VALID`=0, `FRAME_CNT`=0, and a fresh frame delivered afterwards with no stale bytes.
